sprite_compositor: RTL and testbench

- Parametrised N-layer sprite compositor; successor to the fixed two-block, one-man, title/gameover compositor in the graphics path.
- Sits between the VGA scan counter and the sprite ROMs.
- For each scan pixel it computes a per-layer sprite ROM address, waits out ROM latency, and priority-composites the layers with mask keying over a background colour.
- Layer placement registers are double-buffered and committed at frame start, so sprites never tear mid-frame.

---
 rtl/sprite_compositor.sv | 190 +++++++++++++++++++
 tb/tb_sprite_compositor.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/sprite_compositor.sv
// N-layer sprite compositor: per-layer ROM addressing, ROM-latency alignment and
// priority mask-keyed compositing over a background. `SPRITE_COMPOSITOR_BLEND_EN` adds 50% blending.
module sprite_compositor #(
    parameter int          NUM_LAYERS = 4,
    parameter int          COORD_W    = 11,
    parameter int          SPR_W      = 180,
    parameter int          SPR_H      = 180,
    parameter int          ADDR_W     = 18,
    parameter int          ROM_LAT    = 1,
    parameter int          MASK_TH    = 5,
    parameter logic [11:0] BG_COLOR   = 12'hfff,
    localparam int         LAYER_W    = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_valid,
    input  logic [COORD_W-1:0]           i_x_read,
    input  logic [COORD_W-1:0]           i_y_read,
    input  logic                         i_frame_start,
    input  logic                         i_cfg_we,
    input  logic [LAYER_W-1:0]           i_cfg_layer,
    input  logic [1:0]                   i_cfg_field,
    input  logic [COORD_W-1:0]           i_cfg_data,
    output logic [NUM_LAYERS*ADDR_W-1:0] o_rom_addr,
    input  logic [NUM_LAYERS*12-1:0]     i_rom_rgb,
    input  logic [NUM_LAYERS*4-1:0]      i_rom_mask,
    output logic                         o_valid,
    output logic [3:0]                   o_r,
    output logic [3:0]                   o_g,
    output logic [3:0]                   o_b
);

`ifdef SPRITE_COMPOSITOR_BLEND_EN
    // Per-channel average of two RGB444 pixels, truncating.
    function automatic logic [11:0] blend_px(input logic [11:0] a, input logic [11:0] b);
        logic [4:0] sr, sg, sb;
        sr = {1'b0, a[11:8]} + {1'b0, b[11:8]};
        sg = {1'b0, a[7:4]}  + {1'b0, b[7:4]};
        sb = {1'b0, a[3:0]}  + {1'b0, b[3:0]};
        return {sr[4:1], sg[4:1], sb[4:1]};
    endfunction
`endif

    logic [COORD_W-1:0]    sh_x_r     [NUM_LAYERS];
    logic [COORD_W-1:0]    sh_y_r     [NUM_LAYERS];
    logic [COORD_W-1:0]    sh_frame_r [NUM_LAYERS];
    logic [NUM_LAYERS-1:0] sh_en_r;
    logic [COORD_W-1:0]    act_x_r     [NUM_LAYERS];
    logic [COORD_W-1:0]    act_y_r     [NUM_LAYERS];
    logic [COORD_W-1:0]    act_frame_r [NUM_LAYERS];
    logic [NUM_LAYERS-1:0] act_en_r;

    logic [COORD_W-1:0]    lx_s   [NUM_LAYERS];
    logic [COORD_W-1:0]    ly_s   [NUM_LAYERS];
    logic [ADDR_W-1:0]     addr_s [NUM_LAYERS];
    logic [NUM_LAYERS-1:0] hit_s;

    logic [NUM_LAYERS*ADDR_W-1:0] rom_addr_r;
    logic                         valid1_r;
    logic [NUM_LAYERS-1:0]        hit1_r;
    logic [ROM_LAT-1:0]           vpipe_r;
    logic [NUM_LAYERS-1:0]        hpipe_r [ROM_LAT];
    logic                         valid_d_s;
    logic [NUM_LAYERS-1:0]        hit_d_s;
    logic [11:0]                  pix_s;
    logic                         valid_r;
    logic [11:0]                  rgb_r;

    // Shadow config writes and frame-start commit; the commit copies the pre-write shadow.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NUM_LAYERS; k++) begin
                sh_x_r[k]      <= {COORD_W{1'b0}};
                sh_y_r[k]      <= {COORD_W{1'b0}};
                sh_frame_r[k]  <= {COORD_W{1'b0}};
                act_x_r[k]     <= {COORD_W{1'b0}};
                act_y_r[k]     <= {COORD_W{1'b0}};
                act_frame_r[k] <= {COORD_W{1'b0}};
            end
            sh_en_r  <= {NUM_LAYERS{1'b0}};
            act_en_r <= {NUM_LAYERS{1'b0}};
        end else begin
            for (int k = 0; k < NUM_LAYERS; k++) begin
                if (i_frame_start) begin
                    act_x_r[k]     <= sh_x_r[k];
                    act_y_r[k]     <= sh_y_r[k];
                    act_frame_r[k] <= sh_frame_r[k];
                    act_en_r[k]    <= sh_en_r[k];
                end
                // Out-of-range layer indices never match any k and are dropped.
                if (i_cfg_we && (i_cfg_layer == LAYER_W'(k))) begin
                    case (i_cfg_field)
                        2'd0:    sh_x_r[k]     <= i_cfg_data;
                        2'd1:    sh_y_r[k]     <= i_cfg_data;
                        2'd2:    sh_frame_r[k] <= i_cfg_data;
                        2'd3:    sh_en_r[k]    <= i_cfg_data[0];
                        default: sh_en_r[k]    <= sh_en_r[k];
                    endcase
                end
            end
        end
    end

    // Local sprite coordinates, hit test and ROM address; wrapped offsets fail the unsigned compare.
    always_comb begin
        for (int k = 0; k < NUM_LAYERS; k++) begin
            lx_s[k]  = i_x_read - act_x_r[k];
            ly_s[k]  = i_y_read - act_y_r[k];
            hit_s[k] = act_en_r[k] && (32'(lx_s[k]) < 32'(SPR_W)) && (32'(ly_s[k]) < 32'(SPR_H));
            if (hit_s[k]) begin
                addr_s[k] = ADDR_W'(32'(act_frame_r[k]) * 32'(SPR_W * SPR_H)
                                  + 32'(ly_s[k]) * 32'(SPR_W) + 32'(lx_s[k]));
            end else begin
                addr_s[k] = {ADDR_W{1'b0}};
            end
        end
    end

    // Stage 1 registers: ROM addresses, pixel valid and hit vector.
    always_ff @(posedge clk) begin
        if (rst) begin
            rom_addr_r <= {(NUM_LAYERS*ADDR_W){1'b0}};
            valid1_r   <= 1'b0;
            hit1_r     <= {NUM_LAYERS{1'b0}};
        end else begin
            valid1_r <= i_valid;
            hit1_r   <= hit_s;
            for (int k = 0; k < NUM_LAYERS; k++) begin
                rom_addr_r[k*ADDR_W +: ADDR_W] <= addr_s[k];
            end
        end
    end

    assign o_rom_addr = rom_addr_r;

    // Delay valid and hits by the ROM latency so they line up with the ROM data.
    always_ff @(posedge clk) begin
        if (rst) begin
            vpipe_r <= {ROM_LAT{1'b0}};
            for (int i = 0; i < ROM_LAT; i++) begin
                hpipe_r[i] <= {NUM_LAYERS{1'b0}};
            end
        end else begin
            vpipe_r[0] <= valid1_r;
            hpipe_r[0] <= hit1_r;
            for (int i = 1; i < ROM_LAT; i++) begin
                vpipe_r[i] <= vpipe_r[i-1];
                hpipe_r[i] <= hpipe_r[i-1];
            end
        end
    end

    assign valid_d_s = vpipe_r[ROM_LAT-1];
    assign hit_d_s   = hpipe_r[ROM_LAT-1];

    // Ascending-priority compositing: later (higher) opaque layers overwrite earlier ones.
    always_comb begin
        pix_s = BG_COLOR;
        for (int k = 0; k < NUM_LAYERS; k++) begin
            if (hit_d_s[k] && (32'(i_rom_mask[k*4 +: 4]) > 32'(MASK_TH))) begin
                pix_s = i_rom_rgb[k*12 +: 12];
            end
`ifdef SPRITE_COMPOSITOR_BLEND_EN
            else if (hit_d_s[k] && (i_rom_mask[k*4 +: 4] != 4'd0)) begin
                pix_s = blend_px(i_rom_rgb[k*12 +: 12], pix_s);
            end
`endif
            else begin
                pix_s = pix_s;
            end
        end
    end

    // Stage 2 output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_r <= 1'b0;
            rgb_r   <= BG_COLOR;
        end else begin
            valid_r <= valid_d_s;
            rgb_r   <= pix_s;
        end
    end

    assign o_valid = valid_r;
    assign o_r     = rgb_r[11:8];
    assign o_g     = rgb_r[7:4];
    assign o_b     = rgb_r[3:0];

endmodule

// File: tb/tb_sprite_compositor.sv
// Directed self-checking bench for sprite_compositor with a cycle-stamped scoreboard.
module tb_sprite_compositor;
    localparam int NL  = 4;
    localparam int CW  = 11;
    localparam int AW  = 18;
    localparam int RL  = 1;
    localparam int LAT = 2 + RL;

    logic            clk = 1'b0;
    logic            rst;
    logic            i_valid;
    logic [CW-1:0]   i_x_read, i_y_read;
    logic            i_frame_start, i_cfg_we;
    logic [1:0]      i_cfg_layer, i_cfg_field;
    logic [CW-1:0]   i_cfg_data;
    logic [NL*AW-1:0] o_rom_addr, b_rom_addr;
    logic [NL*12-1:0] i_rom_rgb;
    logic [NL*4-1:0]  i_rom_mask;
    logic            o_valid, b_valid;
    logic [3:0]      o_r, o_g, o_b, b_r, b_g, b_b;

    typedef struct {
        logic [11:0] rgb;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   n_assert = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sprite_compositor #(.NUM_LAYERS(NL), .ROM_LAT(RL)) dut (
        .clk(clk), .rst(rst), .i_valid(i_valid), .i_x_read(i_x_read), .i_y_read(i_y_read),
        .i_frame_start(i_frame_start), .i_cfg_we(i_cfg_we), .i_cfg_layer(i_cfg_layer),
        .i_cfg_field(i_cfg_field), .i_cfg_data(i_cfg_data), .o_rom_addr(o_rom_addr),
        .i_rom_rgb(i_rom_rgb), .i_rom_mask(i_rom_mask), .o_valid(o_valid),
        .o_r(o_r), .o_g(o_g), .o_b(o_b)
    );

    sprite_compositor #(.NUM_LAYERS(NL), .ROM_LAT(RL), .BG_COLOR(12'h000)) dut_b (
        .clk(clk), .rst(rst), .i_valid(i_valid), .i_x_read(i_x_read), .i_y_read(i_y_read),
        .i_frame_start(i_frame_start), .i_cfg_we(i_cfg_we), .i_cfg_layer(i_cfg_layer),
        .i_cfg_field(i_cfg_field), .i_cfg_data(i_cfg_data), .o_rom_addr(b_rom_addr),
        .i_rom_rgb(i_rom_rgb), .i_rom_mask(i_rom_mask), .o_valid(b_valid),
        .o_r(b_r), .o_g(b_g), .o_b(b_b)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic cfg(input int layer, input int field, input int data, input bit commit);
        i_cfg_we      = 1'b1;
        i_cfg_layer   = 2'(layer);
        i_cfg_field   = 2'(field);
        i_cfg_data    = CW'(data);
        i_frame_start = commit;
        idle(1);
        i_cfg_we      = 1'b0;
        i_frame_start = 1'b0;
    endtask

    task automatic commit_frame();
        i_frame_start = 1'b1;
        idle(1);
        i_frame_start = 1'b0;
    endtask

    task automatic set_rom(input int layer, input logic [11:0] rgb, input logic [3:0] mask);
        i_rom_rgb[layer*12 +: 12] = rgb;
        i_rom_mask[layer*4 +: 4]  = mask;
    endtask

    // Drive one pixel; optionally score it and check one layer's ROM address a cycle later.
    task automatic pix(input int x, input int y, input logic [11:0] exp, input bit push,
                       input int layer, input int eaddr, input string tag);
        i_valid  = 1'b1;
        i_x_read = CW'(x);
        i_y_read = CW'(y);
        if (push) sb.push_back('{exp, cyc + LAT});
        idle(1);
        i_valid = 1'b0;
        if (layer >= 0) chk({tag, "_addr"}, 128'(o_rom_addr[layer*AW +: AW]), 128'(eaddr));
    endtask

    initial begin
        logic [11:0] exp_m3_5, exp_m1_5, exp_blend;
`ifdef SPRITE_COMPOSITOR_BLEND_EN
        exp_m3_5  = 12'h222;
        exp_m1_5  = 12'h555;
        exp_blend = 12'h777;
`else
        exp_m3_5  = 12'h111;
        exp_m1_5  = 12'hfff;
        exp_blend = 12'h000;
`endif
        rst = 1'b1; i_valid = 1'b0; i_x_read = '0; i_y_read = '0;
        i_frame_start = 1'b0; i_cfg_we = 1'b0; i_cfg_layer = '0; i_cfg_field = '0; i_cfg_data = '0;
        i_rom_rgb = '0; i_rom_mask = '0;

        fork
            forever begin
                exp_t e;
                @(negedge clk);
                if (o_valid) begin
                    n_assert++;
                    assert (sb.size() != 0) else begin
                        n_fail++;
                        $error("FAIL unexpected_valid: observed o_valid=1 at cycle %0d expected no pending pixel", cyc);
                    end
                    if (sb.size() != 0) begin
                        e = sb.pop_front();
                        chk("pixel", 128'({o_r, o_g, o_b}), 128'(e.rgb));
                        chk("latency", 128'(cyc), 128'(e.cyc));
                    end
                end
            end
        join_none

        idle(3);
        rst = 1'b0;
        chk("rst_valid", 128'(o_valid), 128'(1'b0));
        chk("rst_rgb", 128'({o_r, o_g, o_b}), 128'(12'hfff));
        chk("rst_addr", 128'(o_rom_addr), 128'(0));

        // No configuration: every pixel is background.
        set_rom(0, 12'h0a0, 4'hf); set_rom(2, 12'h222, 4'hf);
        for (int i = 0; i < 4; i++) pix(i * 37, i * 11, 12'hfff, 1'b1, 0, 0, "nocfg");
        idle(LAT + 1);

        // Mid-frame reset discards in-flight pixels.
        pix(1, 1, 12'hfff, 1'b0, -1, 0, "drop");
        i_valid = 1'b1; rst = 1'b1;
        idle(1);
        rst = 1'b0; i_valid = 1'b0;
        idle(LAT + 2);

        // Single layer edges.
        cfg(0, 0, 100, 1'b0); cfg(0, 1, 50, 1'b0); cfg(0, 2, 2, 1'b0); cfg(0, 3, 1, 1'b0);
        commit_frame();
        pix(100, 50, 12'h0a0, 1'b1, 0, 64800, "edge_origin");
        pix(279, 229, 12'h0a0, 1'b1, 0, 97199, "edge_corner");
        pix(280, 50, 12'hfff, 1'b1, 0, 0, "edge_xmiss");
        pix(100, 230, 12'hfff, 1'b1, 0, 0, "edge_ymiss");
        pix(99, 50, 12'hfff, 1'b1, 0, 0, "edge_neg");
        idle(LAT);

        // Priority and mask keying on layers 1 and 3.
        cfg(0, 3, 0, 1'b0);
        cfg(1, 0, 250, 1'b0); cfg(1, 1, 150, 1'b0); cfg(1, 3, 1, 1'b0);
        cfg(3, 0, 300, 1'b0); cfg(3, 1, 200, 1'b0); cfg(3, 2, 1, 1'b0); cfg(3, 3, 1, 1'b0);
        commit_frame();
        set_rom(1, 12'h111, 4'hf); set_rom(3, 12'h333, 4'hf);
        pix(300, 200, 12'h333, 1'b1, 3, 32400, "prio_15_15");
        chk("prio_l1_addr", 128'(o_rom_addr[1*AW +: AW]), 128'(9050));
        idle(LAT);
        set_rom(3, 12'h333, 4'h5);
        pix(300, 200, exp_m3_5, 1'b1, -1, 0, "prio_15_5");
        idle(LAT);
        set_rom(3, 12'h333, 4'h6);
        pix(300, 200, 12'h333, 1'b1, -1, 0, "prio_15_6");
        idle(LAT);
        set_rom(1, 12'h111, 4'h5); set_rom(3, 12'h333, 4'h5);
        pix(300, 200, exp_m1_5, 1'b1, -1, 0, "prio_5_5");
        idle(LAT);
        set_rom(1, 12'h111, 4'hf); set_rom(3, 12'h333, 4'hf);

        // Double buffering, including a write coincident with the commit pulse.
        cfg(0, 0, 10, 1'b0); cfg(0, 1, 0, 1'b0); cfg(0, 3, 1, 1'b0);
        pix(10, 0, 12'hfff, 1'b1, 0, 0, "dbuf_pre");
        commit_frame();
        pix(10, 0, 12'h0a0, 1'b1, 0, 64800, "dbuf_post");
        cfg(0, 0, 500, 1'b1);
        pix(10, 0, 12'h0a0, 1'b1, 0, 64800, "dbuf_same_old");
        pix(500, 0, 12'hfff, 1'b1, 0, 0, "dbuf_same_new");
        commit_frame();
        pix(500, 0, 12'h0a0, 1'b1, 0, 64800, "dbuf_second");
        pix(10, 0, 12'hfff, 1'b1, 0, 0, "dbuf_wrap_miss");

        // Origin hit, coordinate wrap miss and address truncation.
        cfg(0, 0, 0, 1'b0); cfg(0, 2, 3, 1'b0);
        commit_frame();
        pix(0, 0, 12'h0a0, 1'b1, 0, 97200, "zero_hit");
        pix(2047, 0, 12'hfff, 1'b1, 0, 0, "wrap_miss");
        pix(179, 179, 12'h0a0, 1'b1, 0, 129599, "far_corner");
        cfg(0, 2, 9, 1'b0);
        commit_frame();
        pix(0, 0, 12'h0a0, 1'b1, 0, 29456, "addr_trunc");
        idle(LAT);

        // Half-mask on a white sprite over a black background.
        set_rom(0, 12'hfff, 4'h3);
        pix(0, 0, 12'hfff, 1'b1, 0, 29456, "blend_main");
        chk("blend_b_addr", 128'(b_rom_addr), 128'(29456));
        idle(LAT - 1);
        chk("blend_b_valid", 128'(b_valid), 128'(1'b1));
        chk("blend_b_rgb", 128'({b_r, b_g, b_b}), 128'(exp_blend));

        idle(LAT + 3);
        chk("sb_drained", 128'(sb.size()), 128'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
